// File: rtl/cfg_pkg.sv
// cfg_pkg: shared constants and state encoding for the row configuration loader
package cfg_pkg;
    localparam int CELL_CFG_W = 69;
    localparam int ROW_CELLS = 8;
    localparam int ROW_PROG_W = CELL_CFG_W * ROW_CELLS;
    localparam logic [7:0] CFG_SYNC = 8'hA5;
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} cfg_state_t;
endpackage

// File: rtl/cfg_frame_timer.sv
// cfg_frame_timer: idle-cycle counter that flags when a frame has stalled too long
module cfg_frame_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt;
    // count idle cycles, holding at the limit until cleared
    always_ff @(posedge clk)
        if (!rst_n || clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + 1'b1;
    assign expired = cnt == TW'(TIMEOUT);
endmodule

// File: rtl/row_cfg_loader.sv
// row_cfg_loader: assembles a framed, checksummed byte stream and commits it atomically to prog
module row_cfg_loader
    import cfg_pkg::*;
#(
    parameter int PROG_W = ROW_PROG_W,
    parameter logic [7:0] SYNC = CFG_SYNC,
    parameter int TIMEOUT = 1024
) (
    input  logic              clb_clk,
    input  logic              clb_rst_n,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              abort,
    output logic [PROG_W-1:0] prog,
    output logic              cfg_valid,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic              busy
);
    localparam int NBYTES = PROG_W / 8;
    localparam int CW = $clog2(NBYTES);
    cfg_state_t state, state_n;
    logic [PROG_W-1:0] shadow;
    logic [7:0] csum;
    logic [CW-1:0] count;
    logic acc, in_frame, expired, commit, err, shift;
    assign acc = s_valid && s_ready;
    assign in_frame = state == LOAD || state == CHECK;
    cfg_frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clb_clk),
        .rst_n(clb_rst_n),
        .clr(acc || !in_frame),
        .en(in_frame),
        .expired(expired)
    );
    // state register
    always_ff @(posedge clb_clk)
        if (!clb_rst_n) state <= IDLE;
        else state <= state_n;
    // next state and commit/error decisions; abort beats timeout beats data
    always_comb begin
        state_n = state;
        commit = 1'b0;
        err = 1'b0;
        shift = 1'b0;
        case (state)
            IDLE: state_n = acc && s_data == SYNC ? LOAD : IDLE;
            LOAD: begin
                if (abort) state_n = IDLE;
                else if (expired) begin
                    err = 1'b1;
                    state_n = DONE;
                end else if (acc) begin
                    shift = 1'b1;
                    state_n = count == CW'(NBYTES - 1) ? CHECK : LOAD;
                end
            end
            CHECK: begin
                if (abort) state_n = IDLE;
                else if (expired) begin
                    err = 1'b1;
                    state_n = DONE;
                end else if (acc) begin
                    commit = s_data == csum;
                    err = s_data != csum;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // shadow assembly, checksum, commit and registered status outputs
    always_ff @(posedge clb_clk) begin
        if (!clb_rst_n) begin
            shadow <= '0;
            csum <= '0;
            count <= '0;
            prog <= '0;
            cfg_valid <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err <= 1'b0;
            busy <= 1'b0;
            s_ready <= 1'b0;
        end else begin
            cfg_done <= commit;
            cfg_err <= err;
            busy <= state_n == LOAD || state_n == CHECK;
            s_ready <= state_n != DONE;
            if (commit) begin
                prog <= shadow;
                cfg_valid <= 1'b1;
            end
            if (state == IDLE && acc && s_data == SYNC) begin
                csum <= '0;
                count <= '0;
            end else if (shift) begin
                shadow <= {shadow[PROG_W-9:0], s_data};
                csum <= csum ^ s_data;
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_row_cfg_loader.sv
// tb_row_cfg_loader: scoreboard-driven self-checking bench for row_cfg_loader
module tb_row_cfg_loader;
    localparam int PW = 552;
    localparam int TO = 16;
    typedef struct packed {
        logic          done;
        logic [PW-1:0] prog;
    } exp_t;
    logic clk = 1'b0;
    logic clb_rst_n, s_valid, s_ready, abort, cfg_valid, cfg_done, cfg_err, busy;
    logic [7:0] s_data;
    logic [PW-1:0] prog;
    logic [7:0] pl [69];
    logic [PW-1:0] model_prog;
    logic model_valid;
    exp_t sb [$];
    exp_t me;
    int checks = 0;
    int errors = 0;
    int ndone = 0;

    row_cfg_loader #(.TIMEOUT(TO)) dut (
        .clb_clk(clk),
        .clb_rst_n(clb_rst_n),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .abort(abort),
        .prog(prog),
        .cfg_valid(cfg_valid),
        .cfg_done(cfg_done),
        .cfg_err(cfg_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // scoreboard: every done/err pulse must match the oldest pushed expectation
    always @(negedge clk)
        if (clb_rst_n === 1'b1 && (cfg_done === 1'b1 || cfg_err === 1'b1)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected pulse done=%b err=%b", cfg_done, cfg_err);
            end else begin
                me = sb.pop_front();
                if (cfg_done !== me.done || cfg_err !== !me.done || prog !== me.prog) begin
                    errors++;
                    $display("FAIL scoreboard: done=%b err=%b prog=%h required done=%b prog=%h",
                             cfg_done, cfg_err, prog, me.done, me.prog);
                end
            end
            if (cfg_done === 1'b1) ndone++;
        end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        s_valid = 1'b1;
        s_data = b;
        n = 0;
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (s_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_byte: s_ready=%b required 1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cs, input bit gaps);
        logic [PW-1:0] e;
        logic [7:0] x;
        e = '0;
        x = '0;
        send_byte(8'hA5, gaps);
        for (int i = 0; i < 69; i++) begin
            send_byte(pl[i], gaps);
            x ^= pl[i];
            e = {e[PW-9:0], pl[i]};
        end
        if (cs == x) begin
            sb.push_back('{1'b1, e});
            model_prog = e;
            model_valid = 1'b1;
        end else sb.push_back('{1'b0, model_prog});
        send_byte(cs, gaps);
    endtask

    task automatic do_reset();
        clb_rst_n = 1'b0;
        s_valid = 1'b0;
        abort = 1'b0;
        s_data = '0;
        model_prog = '0;
        model_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (prog !== '0 || cfg_valid !== 1'b0 || cfg_done !== 1'b0 || cfg_err !== 1'b0 ||
            busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset: prog_nz=%b valid=%b done=%b err=%b busy=%b ready=%b required all 0",
                     |prog, cfg_valid, cfg_done, cfg_err, busy, s_ready);
        end
        clb_rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b required 1 0", s_ready, busy);
        end
    endtask

    task automatic test_good_frame();
        for (int i = 0; i < 69; i++) pl[i] = 8'(i);
        send_frame(8'h44, 1'b0);
        checks++;
        if (s_ready !== 1'b0 || cfg_valid !== 1'b1 || cfg_done !== 1'b1) begin
            errors++;
            $display("FAIL good_after_cs: ready=%b valid=%b done=%b required 0 1 1", s_ready, cfg_valid, cfg_done);
        end
        checks++;
        if (prog[551:544] !== 8'h00 || prog[543:536] !== 8'h01 || prog[7:0] !== 8'h44) begin
            errors++;
            $display("FAIL good_bytes: %h %h %h required 00 01 44", prog[551:544], prog[543:536], prog[7:0]);
        end
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL good_done_cycle: ready=%b done=%b required 1 0", s_ready, cfg_done);
        end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        clb_rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 69; i++) pl[i] = 8'(i);
        send_frame(8'h45, 1'b0);
        checks++;
        if (cfg_err !== 1'b1 || prog !== '0 || cfg_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_cs: err=%b prog_nz=%b valid=%b required 1 0 0", cfg_err, |prog, cfg_valid);
        end
        @(negedge clk);
        checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_cs_pulse: err=%b busy=%b required 0 0", cfg_err, busy);
        end
    endtask

    task automatic test_sync_hunt();
        send_byte(8'h00, 1'b1);
        send_byte(8'h3C, 1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hunt_idle: busy=%b required 0", busy);
        end
        for (int i = 0; i < 69; i++) pl[i] = 8'(i);
        send_frame(8'h44, 1'b1);
        checks++;
        if (prog[551:544] !== 8'h00 || prog[543:536] !== 8'h01 || prog[7:0] !== 8'h44 || cfg_valid !== 1'b1) begin
            errors++;
            $display("FAIL hunt_prog: %h %h %h valid=%b required 00 01 44 1",
                     prog[551:544], prog[543:536], prog[7:0], cfg_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        for (int i = 0; i < 69; i++) pl[i] = 8'(8'hF0 ^ i);
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(pl[i], 1'b0);
        sb.push_back('{1'b0, model_prog});
        n = 0;
        while (cfg_err !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < TO || n > TO + 1) begin
            errors++;
            $display("FAIL timeout_latency: idle cycles=%0d required %0d..%0d", n, TO, TO + 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_busy: busy=%b required 0", busy);
        end
        @(negedge clk);
        for (int i = 0; i < 69; i++) pl[i] = 8'(i);
        send_frame(8'h44, 1'b0);
        checks++;
        if (prog !== model_prog || prog[7:0] !== 8'h44) begin
            errors++;
            $display("FAIL timeout_recover: prog[7:0]=%h required 44", prog[7:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 30; i++) send_byte(8'hFF, 1'b0);
        abort = 1'b1;
        s_valid = 1'b1;
        s_data = 8'h11;
        @(negedge clk);
        abort = 1'b0;
        s_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || cfg_err !== 1'b0 || prog !== model_prog) begin
            errors++;
            $display("FAIL abort: busy=%b err=%b prog_same=%b required 0 0 1", busy, cfg_err, prog === model_prog);
        end
        repeat (TO + 5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cfg_valid !== 1'b1 || prog !== model_prog) begin
            errors++;
            $display("FAIL abort_idle: busy=%b valid=%b required 0 1", busy, cfg_valid);
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 30; i++) send_byte(8'h77, 1'b0);
        clb_rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (prog !== '0 || cfg_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: prog_nz=%b valid=%b busy=%b ready=%b required 0 0 0 0",
                     |prog, cfg_valid, busy, s_ready);
        end
        model_prog = '0;
        model_valid = 1'b0;
        clb_rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int d0;
        logic [PW-1:0] want;
        d0 = ndone;
        want = {69{8'hC3}};
        for (int i = 0; i < 69; i++) pl[i] = 8'h5A;
        send_frame(8'h5A, 1'b0);
        for (int i = 0; i < 69; i++) pl[i] = 8'hC3;
        send_frame(8'hC3, 1'b0);
        @(negedge clk);
        checks++;
        if (ndone - d0 !== 2) begin
            errors++;
            $display("FAIL b2b_pulses: done pulses=%0d required 2", ndone - d0);
        end
        checks++;
        if (prog !== want || cfg_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_prog: prog=%h valid=%b required all C3, 1", prog, cfg_valid);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_sync_hunt();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d outstanding required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/row_cfg_loader.md
Name: row_cfg_loader

Overview:
- Configuration writer for one logic-cell row: the producing end of the row's 552-bit `prog` interface.
- Accepts a byte stream over a valid/ready handshake and assembles a framed bitstream into a shadow register.
- Checks the frame checksum; on a match, commits the shadow to `prog` atomically, so the row never sees a partial configuration.
- Sits between the bitstream source (host/serial front end) and the row's `prog` input.

Parameters:
- PROG_W, 552, width of the `prog` output. Must be a multiple of 8 (8 cells x 69 bits).
- NBYTES, PROG_W/8 = 69, payload bytes per frame. Derived; do not override.
- SYNC, 8'hA5, frame start byte.
- TIMEOUT, 1024, maximum idle cycles between accepted bytes inside a frame.

Ports:
- clb_clk, in, 1: clock. All state changes on the rising edge.
- clb_rst_n, in, 1: synchronous active-low reset.
- s_data, in, 8: stream byte.
- s_valid, in, 1: `s_data` is valid.
- s_ready, out, 1: loader can accept a byte. A byte transfers on a clock edge with `s_valid && s_ready`.
- abort, in, 1: discard the frame in progress.
- prog, out, PROG_W: committed configuration. Bits [551:483] go to cell 1 … bits [68:0] go to cell 8.
- cfg_valid, out, 1: a good frame has been committed since reset (level).
- cfg_done, out, 1: one-cycle pulse on commit.
- cfg_err, out, 1: one-cycle pulse on checksum mismatch or timeout.
- busy, out, 1: high in LOAD or CHECK.

Behaviour:
- Reset (`clb_rst_n` = 0 at an edge):
  - state = IDLE; `prog` = 0; `cfg_valid`, `cfg_done`, `cfg_err`, `busy` = 0.
  - `s_ready` = 0 while reset is asserted; byte count, checksum and timer cleared.
  - Reset mid-frame discards the frame; `prog` goes to 0 per the reset rule.
- Outputs: all registered. `s_ready` is 1 in IDLE, LOAD and CHECK, and 0 in DONE and in reset.
- IDLE:
  - Every accepted byte is examined. `SYNC` → LOAD with count = 0 and checksum = 0.
  - Any other byte is dropped silently (sync hunt).
- LOAD:
  - Each accepted byte does: shadow <= {shadow[PROG_W-9:0], byte}; checksum ^= byte; count++.
  - The first payload byte therefore ends in shadow[551:544] and the last in shadow[7:0].
  - When the byte with count = NBYTES-1 is accepted → CHECK.
- CHECK:
  - The next accepted byte is the checksum.
  - Equal to the XOR of all payload bytes: at that same edge, `prog` <= shadow, `cfg_valid` <= 1, `cfg_done` <= 1 (high the following cycle, coincident with the new `prog`).
  - Not equal: `cfg_err` <= 1 and `prog` unchanged.
  - Either outcome → DONE.
- DONE: lasts one cycle with `s_ready` = 0, then → IDLE. `cfg_done`/`cfg_err` clear after one cycle.
- Timeout:
  - In LOAD/CHECK the idle timer counts cycles with no accepted byte; it resets to 0 on each accepted byte.
  - When the timer reaches TIMEOUT: `cfg_err` pulse, → DONE, `prog` unchanged.
- abort:
  - In LOAD/CHECK: → IDLE next edge, no `cfg_err`, `prog` unchanged. A byte offered in the same cycle is dropped.
  - In IDLE/DONE: no effect.
- Priority: reset > abort > timeout > byte acceptance.
- A `SYNC`-valued byte inside the payload is ordinary data; there is no resync mid-frame.
- `prog` changes only on a good commit or reset. There is never a partial update.
- Back-to-back frames: the minimum gap is the one DONE cycle. The source must hold `s_valid`/`s_data` stable while `s_ready` = 0.

Decomposition:
- Shared package `cfg_pkg`:
  - constants CELL_CFG_W = 69, ROW_CELLS = 8, ROW_PROG_W = 552, CFG_SYNC = 8'hA5;
  - state enum {IDLE, LOAD, CHECK, DONE}.
- One natural sub-module, `cfg_frame_timer`: idle counter with clear/enable and a `expired` flag.
- The shift register, checksum and FSM stay in the top module.

Test Plan:
- Good frame: send A5, payload bytes 0x00..0x44 (byte i = i), checksum 0x44.
  Required: `cfg_done` pulse; `prog`[551:544] = 0x00, [543:536] = 0x01, [7:0] = 0x44; `cfg_valid` = 1; `s_ready` = 0 for exactly one cycle after the checksum byte.
- Bad checksum: same frame with checksum 0x45.
  Required: `cfg_err` pulse; `prog` holds its previous value (all 0 after reset); `cfg_valid` unchanged.
- Sync hunt plus `s_valid` gaps: send 00, 3C, A5, then the good frame with random `s_valid` deassertion.
  Required: `prog` as in the good-frame case; the leading 00/3C are ignored.
- Timeout (TIMEOUT = 16): A5 plus 10 payload bytes, then 16 idle cycles.
  Required: `cfg_err` pulse, `busy` = 0 afterwards. A following good frame commits correctly.
- Abort/reset mid-frame:
  - `abort` after 30 bytes → IDLE, no `cfg_err`, `prog` unchanged.
  - `clb_rst_n` = 0 after 30 bytes → `prog` = 0, `cfg_valid` = 0.
- Back-to-back frames: two good frames separated only by the DONE cycle; payload A all 0x5A, payload B all 0xC3.
  Required: checksums 0x5A/0xC3 (odd count); two `cfg_done` pulses; final `prog` = {69{8'hC3}}.
